// File: rtl/fft_frame_controller.sv
// Frame sequencer for the 8-point FFT datapath: capture -> transform -> serialize,
// with per-phase stall timeout, abort, and a wrapping completed-frame counter.
module fft_frame_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   continuous,
  input  logic                   abort,
  output logic                   deser_start,
  input  logic                   deser_done,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic                   result_load,
  output logic                   ser_start,
  input  logic                   ser_done,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [2:0]             state
);

  localparam int PW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0]          PHASE_LAST = PW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0]          PHASE_ONE  = PW'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_LATCH   = 3'd3,
    S_DRAIN   = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                 cur_state, nxt_state;
  logic [PW-1:0]          phase_cnt, phase_cnt_n;
  logic [COUNT_WIDTH-1:0] frame_count_n;
  logic                   deser_start_n, fft_start_n, result_load_n, ser_start_n;
  logic                   frame_done_n, timeout_err_n, busy_n;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    nxt_state     = cur_state;
    deser_start_n = 1'b0;
    fft_start_n   = 1'b0;
    result_load_n = 1'b0;
    ser_start_n   = 1'b0;
    frame_done_n  = 1'b0;
    frame_count_n = frame_count;
    timeout_err_n = timeout_err;

    if (abort && cur_state != S_IDLE) begin
      // Abort beats any done strobe; only leaving ERROR clears the sticky flag.
      nxt_state = S_IDLE;
      if (cur_state == S_ERROR) timeout_err_n = 1'b0;
    end else begin
      case (cur_state)
        S_IDLE: if (run) begin
          nxt_state     = S_LOAD;
          deser_start_n = 1'b1;
        end
        S_LOAD: if (deser_done) begin
          nxt_state   = S_COMPUTE;
          fft_start_n = 1'b1;
        end
        S_COMPUTE: begin
          if (fft_done) begin
            nxt_state     = S_LATCH;
            result_load_n = 1'b1;
          end else if (phase_cnt == PHASE_LAST) begin
            nxt_state     = S_ERROR;
            timeout_err_n = 1'b1;
          end
        end
        S_LATCH: begin
          nxt_state   = S_DRAIN;
          ser_start_n = 1'b1;
        end
        S_DRAIN: begin
          if (ser_done) begin
            frame_done_n  = 1'b1;
            frame_count_n = frame_count + COUNT_ONE;
            if (continuous && run) begin
              nxt_state     = S_LOAD;
              deser_start_n = 1'b1;
            end else begin
              nxt_state = S_IDLE;
            end
          end else if (phase_cnt == PHASE_LAST) begin
            nxt_state     = S_ERROR;
            timeout_err_n = 1'b1;
          end
        end
        S_ERROR: nxt_state = S_ERROR;
        default: nxt_state = S_IDLE;
      endcase
    end

    // Any state change restarts the phase counter, so it reads 0 on entry to COMPUTE/DRAIN.
    if (nxt_state != cur_state) begin
      phase_cnt_n = '0;
    end else if (cur_state == S_COMPUTE || cur_state == S_DRAIN) begin
      phase_cnt_n = phase_cnt + PHASE_ONE;
    end else begin
      phase_cnt_n = '0;
    end

    busy_n = (nxt_state != S_IDLE);
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state   <= S_IDLE;
      phase_cnt   <= '0;
      deser_start <= 1'b0;
      fft_start   <= 1'b0;
      result_load <= 1'b0;
      ser_start   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      cur_state   <= nxt_state;
      phase_cnt   <= phase_cnt_n;
      deser_start <= deser_start_n;
      fft_start   <= fft_start_n;
      result_load <= result_load_n;
      ser_start   <= ser_start_n;
      frame_done  <= frame_done_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
      frame_count <= frame_count_n;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_fft_frame_controller.sv
// Scoreboard bench for fft_frame_controller: stimulus queues expected pulse records,
// a negedge monitor pops and compares them whenever they fall due.
module tb_fft_frame_controller;

  localparam int TO = 64;
  localparam int CW = 2;

  localparam logic [4:0] P_DS = 5'b00001;
  localparam logic [4:0] P_FS = 5'b00010;
  localparam logic [4:0] P_RL = 5'b00100;
  localparam logic [4:0] P_SS = 5'b01000;
  localparam logic [4:0] P_FD = 5'b10000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic          deser_done = 1'b0, fft_done = 1'b0, ser_done = 1'b0;
  logic          deser_start, fft_start, result_load, ser_start, frame_done;
  logic          busy, timeout_err;
  logic [CW-1:0] frame_count;
  logic [2:0]    state;

  fft_frame_controller #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .continuous(continuous), .abort(abort),
    .deser_start(deser_start), .deser_done(deser_done),
    .fft_start(fft_start), .fft_done(fft_done),
    .result_load(result_load), .ser_start(ser_start), .ser_done(ser_done),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
    .frame_count(frame_count), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [4:0]    pulses;
    logic [CW-1:0] fcount;
    logic          busy;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [4:0]    mon_p;
  logic [CW-1:0] exp_count = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_evt(input int at, input logic [4:0] p, input logic b);
    exp_t e;
    e.cyc = at; e.pulses = p; e.fcount = exp_count; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle either a record falls due or no pulse may be present.
  always @(negedge clk) begin
    mon_p = {frame_done, ser_start, result_load, fft_start, deser_start};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("pulses", 32'(mon_p), 32'(mon_e.pulses));
      check("frame_count", 32'(frame_count), 32'(mon_e.fcount));
      check("busy", 32'(busy), 32'(mon_e.busy));
    end else if (reset_n && mon_p !== 5'b0) begin
      check("stray_pulse", 32'(mon_p), 32'd0);
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; run = 0; continuous = 0; abort = 0;
    deser_done = 0; fft_done = 0; ser_done = 0;
    step(); step();
    reset_n = 1'b1;
    exp_count = '0;
  endtask

  task automatic start_frame(input bit keep_run);
    run = 1'b1;
    expect_evt(cyc + 1, P_DS, 1'b1);
    step();
    if (!keep_run) run = 1'b0;
  endtask

  task automatic do_load(input int d);
    repeat (d) step();
    deser_done = 1'b1;
    expect_evt(cyc + 1, P_FS, 1'b1);
    step();
    deser_done = 1'b0;
  endtask

  task automatic do_compute(input int d);
    repeat (d) step();
    fft_done = 1'b1;
    expect_evt(cyc + 1, P_RL, 1'b1);
    expect_evt(cyc + 2, P_SS, 1'b1);
    step();
    fft_done = 1'b0;
  endtask

  task automatic do_drain(input int d, input bit restart);
    step();
    repeat (d) step();
    ser_done = 1'b1;
    exp_count = exp_count + 1'b1;
    expect_evt(cyc + 1, restart ? (P_FD | P_DS) : P_FD, restart);
    step();
    ser_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with inputs toggling: everything stays zero.
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom); continuous = 1'($urandom); abort = 1'($urandom);
      deser_done = 1'($urandom); fft_done = 1'($urandom); ser_done = 1'($urandom);
      step();
      check("reset_outputs",
            32'({deser_start, fft_start, result_load, ser_start, frame_done,
                 busy, timeout_err, frame_count, state}), 32'd0);
    end
    run = 0; continuous = 0; abort = 0; deser_done = 0; fft_done = 0; ser_done = 0;
    reset_n = 1'b1;
    repeat (3) begin
      step();
      check("idle_after_reset", 32'({busy, state}), 32'd0);
    end

    // Single frame, non-continuous.
    start_frame(1'b0);
    do_load(10);
    do_compute(5);
    do_drain(17, 1'b0);
    step();
    check("single_count", 32'(frame_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Continuous, three frames, run dropped during frame 3.
    do_reset();
    continuous = 1'b1;
    start_frame(1'b1);
    do_load(3); do_compute(4); do_drain(5, 1'b1);
    do_load(2); do_compute(6); do_drain(3, 1'b1);
    run = 1'b0;
    do_load(4); do_compute(2); do_drain(7, 1'b0);
    continuous = 1'b0;
    step();
    check("cont_state", 32'(state), 32'd0);
    check("cont_count", 32'(frame_count), 32'd3);

    // Timeout in COMPUTE, late fft_done ignored, abort clears.
    do_reset();
    start_frame(1'b0);
    do_load(2);
    repeat (TO - 1) step();
    check("pre_timeout_state", 32'(state), 32'd2);
    check("pre_timeout_err", 32'(timeout_err), 32'd0);
    step();
    check("timeout_state", 32'(state), 32'd5);
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd1);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    check("late_done_state", 32'(state), 32'd5);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_state", 32'(state), 32'd0);
    check("abort_err", 32'(timeout_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // Done strobes on the last counter value beat the timeout.
    start_frame(1'b0);
    do_load(1);
    do_compute(TO - 1);
    check("edge_latch_state", 32'(state), 32'd3);
    check("edge_latch_err", 32'(timeout_err), 32'd0);
    do_drain(TO - 1, 1'b0);
    step();
    check("edge_drain_state", 32'(state), 32'd0);
    check("edge_drain_count", 32'(frame_count), 32'd1);

    // fft_done and abort together on the last counter value: abort wins.
    start_frame(1'b0);
    do_load(1);
    repeat (TO - 1) step();
    fft_done = 1'b1; abort = 1'b1;
    step();
    fft_done = 1'b0; abort = 1'b0;
    check("abort_edge_state", 32'(state), 32'd0);
    check("abort_edge_err", 32'(timeout_err), 32'd0);
    check("abort_edge_count", 32'(frame_count), 32'd1);
    step();

    // Wrap with COUNT_WIDTH=2, plus spurious ser_done in IDLE and LOAD.
    do_reset();
    ser_done = 1'b1; step(); ser_done = 1'b0;
    check("spurious_idle_state", 32'(state), 32'd0);
    check("spurious_idle_count", 32'(frame_count), 32'd0);
    for (int f = 0; f < 5; f++) begin
      start_frame(1'b0);
      if (f == 0) begin
        ser_done = 1'b1; step(); ser_done = 1'b0;
        check("spurious_load_state", 32'(state), 32'd1);
      end
      do_load(2);
      do_compute(3);
      do_drain(4, 1'b0);
    end
    step();
    check("wrap_count", 32'(frame_count), 32'd1);

    repeat (3) step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
